id_ex_pipe_stage: RTL and testbench
===================================

// Module: id_ex_pipe_stage
// PURPOSE
//  Parametrised ID->EX pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Sits between decode/register-read and the ALU stage. Supports back-pressure (stall) and
//  flush (bubble insertion), zeroes control on bubbles, and counts idle EX cycles for profiling.
// PARAMETERS
//  DATA_W     32  width of instr, pc_next, data1, data2, signal, j_value
//  REG_W      5   destination register index width
//  ALUCTRL_W  4   ALU control width
//  CTRL_W     8   packed control {regdsts,regwrt,memread,memwrite,alusrc,memtoreg,jumps,branches}, MSB..LSB
//  CNT_W      16  bubble counter width
// PORTS
//  ck          in   1          clock; all state updates on posedge
//  rst         in   1          synchronous, active-high reset
//  flush       in   1          kill all held entries (branch/jump redirect)
//  in_valid    in   1          ID presents an entry
//  in_ready    out  1          stage can accept; registered, = skid empty
//  in_ctrl     in   CTRL_W     packed control bits
//  in_aluctrl  in   ALUCTRL_W  ALU operation
//  in_instr    in   DATA_W     instruction word
//  in_pc_next  in   DATA_W     PC+4
//  in_data1    in   DATA_W     rs read data
//  in_data2    in   DATA_W     rt read data
//  in_signal   in   DATA_W     sign-extended immediate
//  in_jval     in   DATA_W     jump target
//  in_regdst   in   REG_W      destination register
//  out_valid   out  1          EX entry valid
//  out_ready   in   1          EX consumes entry this cycle
//  out_ctrl/out_aluctrl/out_instr/out_pc_next/out_data1/out_data2/out_signal/out_jval/out_regdst
//              out  as inputs  head entry fields
//  bubble_cnt  out  CNT_W      saturating count of cycles with out_ready=1 and out_valid=0
// BEHAVIOUR
//  - Storage: main reg M (drives outputs) + skid reg S. States: EMPTY(M0,S0), ONE(M1,S0), FULL(M1,S1).
//  - acc = in_valid & in_ready; pop = out_valid & out_ready.
//  - EMPTY: acc -> load M, go ONE. Latency in->out exactly 1 cycle.
//  - ONE: acc&pop -> M<=in, stay ONE; acc&!pop -> S<=in, go FULL; !acc&pop -> EMPTY; else hold.
//  - FULL: in_ready=0; pop -> M<=S, go ONE; else hold. Never accept in FULL.
//  - in_ready is a flop output: 1 in EMPTY/ONE, 0 in FULL (no combinational in_ready<-out_ready path).
//  - Order preserved; no entry dropped or duplicated except by flush/rst.
//  - flush (priority over everything except rst): next state EMPTY, entry offered same cycle
//    discarded, M/S ctrl cleared to 0; data fields may keep stale values.
//  - When out_valid=0, out_ctrl and out_aluctrl forced to 0 (bubble = no write, no mem access).
//  - rst: state EMPTY, all fields 0 (instr=0 is NOP), in_ready=1 next cycle, bubble_cnt=0.
//    rst mid-transfer discards held entries; rst beats flush.
//  - bubble_cnt: +1 each cycle out_ready & !out_valid (rst/flush cycles excluded);
//    saturates at 2^CNT_W-1, no wrap. Not cleared by flush.
// TESTING
//  1 rst, then in_valid=1 instr=0x8C220004 ctrl=0x6A, out_ready=1 -> out_valid=1 next cycle, same fields; in_ready stays 1.
//  2 out_ready=0, push A,B -> after B in_ready=0, out=A; raise out_ready -> A then B on consecutive cycles, in_ready=1 after A pops.
//  3 FULL state + flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; offered entry never appears.
//  4 streaming 100 entries with out_ready toggling 1/0 each cycle -> all 100 out in order, no drops/duplicates.
//  5 CNT_W=4, in_valid=0 out_ready=1 for 20 cycles -> bubble_cnt=15, holds at 15.
//  6 rst asserted in FULL with flush=1 -> all outputs 0, in_ready=1, bubble_cnt=0 next cycle.

Source files
------------

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with a valid/ready handshake, a 2-entry skid buffer,
// flush-driven bubble insertion and a saturating idle-cycle (bubble) counter.
module id_ex_pipe_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int ALUCTRL_W = 4,
  parameter int CTRL_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [ALUCTRL_W-1:0] in_aluctrl,
  input  logic [DATA_W-1:0]    in_instr,
  input  logic [DATA_W-1:0]    in_pc_next,
  input  logic [DATA_W-1:0]    in_data1,
  input  logic [DATA_W-1:0]    in_data2,
  input  logic [DATA_W-1:0]    in_signal,
  input  logic [DATA_W-1:0]    in_jval,
  input  logic [REG_W-1:0]     in_regdst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [ALUCTRL_W-1:0] out_aluctrl,
  output logic [DATA_W-1:0]    out_instr,
  output logic [DATA_W-1:0]    out_pc_next,
  output logic [DATA_W-1:0]    out_data1,
  output logic [DATA_W-1:0]    out_data2,
  output logic [DATA_W-1:0]    out_signal,
  output logic [DATA_W-1:0]    out_jval,
  output logic [REG_W-1:0]     out_regdst,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [1:0]           dbg_state
);

  // Handshake: a transfer happens on a rising edge of ck when valid and ready
  // are both high on that side; in_ready is registered (1 unless both M and S
  // are occupied), so it never depends combinationally on out_ready.

  typedef struct packed {
    logic [CTRL_W-1:0]    ctrl;
    logic [ALUCTRL_W-1:0] aluctrl;
    logic [DATA_W-1:0]    instr;
    logic [DATA_W-1:0]    pc_next;
    logic [DATA_W-1:0]    data1;
    logic [DATA_W-1:0]    data2;
    logic [DATA_W-1:0]    signal;
    logic [DATA_W-1:0]    jval;
    logic [REG_W-1:0]     regdst;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_n;
  entry_t m_q, s_q, in_e;
  logic   acc, pop;
  logic   load_m_in, load_m_s, load_s_in;

  assign in_e = {in_ctrl, in_aluctrl, in_instr, in_pc_next, in_data1,
                 in_data2, in_signal, in_jval, in_regdst};

  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_n   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s_in = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            load_m_in = 1'b1;
            state_n   = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            load_m_in = 1'b1;
          end else if (acc) begin
            load_s_in = 1'b1;
            state_n   = FULL;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            load_m_s = 1'b1;
            state_n  = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready   <= 1'b1;
      bubble_cnt <= '0;
    end else begin
      state_q  <= state_n;
      in_ready <= (state_n != FULL);
      if (flush) begin
        // Data fields may stay stale; only control must read as a bubble.
        m_q.ctrl    <= '0;
        m_q.aluctrl <= '0;
        s_q.ctrl    <= '0;
        s_q.aluctrl <= '0;
      end else begin
        if (load_m_in)     m_q <= in_e;
        else if (load_m_s) m_q <= s_q;
        if (load_s_in)     s_q <= in_e;
      end
      if (!flush && out_ready && !out_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign out_ctrl    = out_valid ? m_q.ctrl    : '0;
  assign out_aluctrl = out_valid ? m_q.aluctrl : '0;
  assign out_instr   = m_q.instr;
  assign out_pc_next = m_q.pc_next;
  assign out_data1   = m_q.data1;
  assign out_data2   = m_q.data2;
  assign out_signal  = m_q.signal;
  assign out_jval    = m_q.jval;
  assign out_regdst  = m_q.regdst;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Randomized bench for id_ex_pipe_stage: a queue-based occupancy model predicts
// every output each cycle, plus directed scenarios for the handshake corner cases.
module tb_id_ex_pipe_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int ALU_W  = 4;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [ALU_W-1:0]  aluctrl;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] signal;
    logic [DATA_W-1:0] jval;
    logic [REG_W-1:0]  regdst;
  } ent_t;

  // clock / reset block
  logic ck = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  always #5 ck = ~ck;

  ent_t drv = '0;
  ent_t obs;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [ALU_W-1:0]  out_aluctrl;
  logic [DATA_W-1:0] out_instr, out_pc_next, out_data1, out_data2, out_signal, out_jval;
  logic [REG_W-1:0]  out_regdst;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [1:0]        dbg_state;

  assign obs = {out_ctrl, out_aluctrl, out_instr, out_pc_next, out_data1,
                out_data2, out_signal, out_jval, out_regdst};

  id_ex_pipe_stage #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ALUCTRL_W(ALU_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .ck(ck), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(drv.ctrl), .in_aluctrl(drv.aluctrl), .in_instr(drv.instr),
    .in_pc_next(drv.pc_next), .in_data1(drv.data1), .in_data2(drv.data2),
    .in_signal(drv.signal), .in_jval(drv.jval), .in_regdst(drv.regdst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_aluctrl(out_aluctrl), .out_instr(out_instr),
    .out_pc_next(out_pc_next), .out_data1(out_data1), .out_data2(out_data2),
    .out_signal(out_signal), .out_jval(out_jval), .out_regdst(out_regdst),
    .bubble_cnt(bubble_cnt), .dbg_state(dbg_state)
  );

  // scoreboard: entries held by the stage, oldest first
  ent_t exp_q[$];
  int   exp_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  bit   streaming = 1'b0;
  int   acc_cnt = 0;
  int   pop_cnt = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rand_entry();
    drv.ctrl    = CTRL_W'($urandom);
    drv.aluctrl = ALU_W'($urandom);
    drv.instr   = $urandom;
    drv.pc_next = $urandom;
    drv.data1   = $urandom;
    drv.data2   = $urandom;
    drv.signal  = $urandom;
    drv.jval    = $urandom;
    drv.regdst  = REG_W'($urandom);
  endtask

  task automatic check_all();
    check("out_valid", out_valid, exp_q.size() > 0);
    check("in_ready", in_ready, exp_q.size() < 2);
    check("bubble_cnt", bubble_cnt, exp_cnt);
    if (exp_q.size() > 0) begin
      check("out_entry", obs, exp_q[0]);
    end else begin
      check("bubble_ctrl", out_ctrl, 0);
      check("bubble_aluctrl", out_aluctrl, 0);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then compare every output #1 after the edge.
  task automatic tick();
    bit acc, pop;
    acc = in_valid && (exp_q.size() < 2) && !flush && !rst;
    pop = (exp_q.size() > 0) && out_ready;
    if (streaming && out_valid && out_ready) begin
      check("stream_order", out_instr, pop_cnt);
      pop_cnt++;
    end
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (out_ready && exp_q.size() == 0 && exp_cnt < CNT_MAX) exp_cnt++;
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(drv);
        acc_cnt++;
      end
    end
    @(posedge ck);
    #1;
    check_all();
  endtask

  task automatic push_one(input logic [31:0] instr);
    rand_entry();
    drv.instr = instr;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    // 1: reset, then a single entry with one-cycle latency
    rst = 1'b1;
    tick();
    tick();
    check("rst_instr", out_instr, 0);
    check("rst_regdst", out_regdst, 0);
    rst = 1'b0;
    rand_entry();
    drv.instr = 32'h8C22_0004;
    drv.ctrl  = 8'h6A;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_instr", out_instr, 32'h8C22_0004);
    check("t1_ctrl", out_ctrl, 8'h6A);
    check("t1_ready", in_ready, 1);
    tick();

    // 2: back-pressure fills the skid, then drains in order
    out_ready = 1'b0;
    push_one(32'hA);
    push_one(32'hB);
    check("t2_full_ready", in_ready, 0);
    check("t2_head_a", out_instr, 32'hA);
    out_ready = 1'b1;
    tick();
    check("t2_head_b", out_instr, 32'hB);
    check("t2_ready_back", in_ready, 1);
    tick();
    check("t2_drained", out_valid, 0);

    // 3: flush while full discards everything including the offered entry
    out_ready = 1'b0;
    push_one(32'h1);
    push_one(32'h2);
    rand_entry();
    drv.instr = 32'hDEAD;
    in_valid  = 1'b1;
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t3_valid", out_valid, 0);
    check("t3_ctrl", out_ctrl, 0);
    check("t3_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // 4: stream 100 entries with out_ready toggling every cycle
    streaming = 1'b1;
    acc_cnt   = 0;
    pop_cnt   = 0;
    for (int cyc = 0; cyc < 1000 && pop_cnt < 100; cyc++) begin
      rand_entry();
      drv.instr = acc_cnt;
      in_valid  = (acc_cnt < 100) && ($urandom_range(0, 3) != 0);
      out_ready = cyc[0];
      tick();
    end
    streaming = 1'b0;
    in_valid  = 1'b0;
    check("t4_accepted", acc_cnt, 100);
    check("t4_popped", pop_cnt, 100);

    // 5: bubble counter saturates at 2^CNT_W-1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("t5_sat", bubble_cnt, CNT_MAX);
    tick();
    check("t5_hold", bubble_cnt, CNT_MAX);

    // 6: reset beats flush while full
    out_ready = 1'b0;
    push_one($urandom);
    push_one($urandom);
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    check("t6_obs_zero", obs, 0);
    check("t6_valid", out_valid, 0);
    check("t6_ready", in_ready, 1);
    check("t6_cnt", bubble_cnt, 0);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      rand_entry();
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst   = 1'b0;
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
